// File: rtl/rvx_wb_pkg.sv
// Shared types and constants for the rvx_core to Wishbone classic bridge.
package rvx_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Pattern handed back to the core when a read is abandoned by the timeout.
  localparam logic [31:0] ERR_READ_DATA_DEFAULT = 32'hDEADBEEF;

  // All-lanes byte select for a bus of data_width bits; callers size-cast the
  // result down to DATA_WIDTH/8 bits.
  function automatic logic [63:0] sel_all(input int data_width);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < data_width / 8) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/rvx_wb_bridge_timeout.sv
// Wait-state watchdog for the bridge: counts bus cycles spent waiting for an
// ack and flags the cycle in which the budget runs out.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    // Timeout switched off: the bridge waits for an ack forever.
    logic unused_inputs;
    assign unused_inputs = clk ^ rst_n ^ clear ^ count_en;
    assign expired       = 1'b0;
  end else begin : g_enabled
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // expired is raised while the last allowed wait cycle is in progress, so
    // the abort edge ends exactly TIMEOUT_CYCLES wait cycles after entry.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Count un-acked bus cycles; cleared whenever the bridge is not on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= '0;
      end else if (clear) begin
        count_q <= '0;
      end else if (count_en && (count_q != LAST_WAIT)) begin
        count_q <= count_q + 1'b1;
      end
    end

    assign expired = count_en && (count_q == LAST_WAIT);
  end

endmodule

// File: rtl/rvx_wb_bridge.sv
// Registered bridge from the rvx_core request/response port to a single-master
// Wishbone classic bus, with byte-select generation, write-first arbitration
// and a wait-state timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; samples write_request, then read_request
// READ  | read bus cycle in progress, waiting for ack or timeout
// WRITE | write bus cycle in progress, waiting for ack or timeout
// DONE  | response pulse cycle; requests are not sampled here
module rvx_wb_bridge
  import rvx_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_READ_DATA  = DATA_WIDTH'(ERR_READ_DATA_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   rw_address,
  input  logic                    read_request,
  input  logic                    write_request,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_response,
  output logic                    write_response,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  output logic                    bus_err_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [SEL_W-1:0] SEL_ONES = SEL_W'(sel_all(DATA_WIDTH));

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rresp_q, rresp_d;
  logic                    wresp_q, wresp_d;
  logic                    err_q, err_d;
  logic                    on_bus;
  logic                    expired;
  logic [ADDR_WIDTH-1:0]   word_addr;

  // Sub-word placement is done by the core through write_strobe, so the low
  // address bits never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^rw_address[1:0];
  assign word_addr        = {rw_address[ADDR_WIDTH-1:2], 2'b00};

  assign on_bus = (state_q == READ) || (state_q == WRITE);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!on_bus),
    .count_en (on_bus && !wb_ack_i),
    .expired  (expired)
  );

  // State, latched access fields and response flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      rresp_q <= 1'b0;
      wresp_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      wresp_q <= wresp_d;
      err_q   <= err_d;
    end
  end

  // Next-state, latching and response decisions; ack is checked before the
  // timeout so a late ack in the expiry cycle still completes normally.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    rresp_d = 1'b0;
    wresp_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_request) begin
          addr_d  = word_addr;
          wdata_d = write_data;
          sel_d   = write_strobe;
          if (write_strobe == '0) begin
            // Nothing to store: acknowledge the core without touching the bus.
            wresp_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else if (read_request) begin
          addr_d  = word_addr;
          sel_d   = SEL_ONES;
          state_d = READ;
        end
      end
      READ: begin
        if (wb_ack_i) begin
          rdata_d = wb_data_i;
          rresp_d = 1'b1;
          state_d = DONE;
        end else if (expired) begin
          rdata_d = ERR_READ_DATA;
          rresp_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (wb_ack_i) begin
          wresp_d = 1'b1;
          state_d = DONE;
        end else if (expired) begin
          wresp_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wb_cyc_o       = on_bus;
  assign wb_stb_o       = on_bus;
  assign wb_we_o        = (state_q == WRITE);
  assign wb_addr_o      = addr_q;
  assign wb_data_o      = wdata_q;
  assign wb_sel_o       = sel_q;
  assign read_data      = rdata_q;
  assign read_response  = rresp_q;
  assign write_response = wresp_q;
  assign bus_err_o      = err_q;

endmodule

// File: tb/tb_rvx_wb_bridge.sv
// Directed bench for rvx_wb_bridge with a small programmable Wishbone slave.
module tb_rvx_wb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rw_address = '0;
  logic          read_request = 1'b0;
  logic          write_request = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [SW-1:0] write_strobe = '0;
  logic [DW-1:0] read_data;
  logic          read_response;
  logic          write_response;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] wb_data_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          bus_err_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rvx_wb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8),
    .ERR_READ_DATA  (32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rw_address     (rw_address),
    .read_request   (read_request),
    .write_request  (write_request),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .read_data      (read_data),
    .read_response  (read_response),
    .write_response (write_response),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_sel_o       (wb_sel_o),
    .wb_data_i      (wb_data_i),
    .wb_ack_i       (wb_ack_i),
    .bus_err_o      (bus_err_o)
  );

  // Slave: acks after slave_waits wait cycles of a bus cycle; -1 never acks.
  bit          slave_en = 1'b1;
  int          slave_waits = 0;
  int          slave_cnt = 0;
  logic [31:0] slave_rdata = '0;

  always @(negedge clk) begin
    if (slave_en) begin
      if (wb_cyc_o && slave_waits >= 0) begin
        if (slave_cnt == slave_waits) begin
          wb_ack_i  = 1'b1;
          wb_data_i = slave_rdata;
        end else begin
          wb_ack_i = 1'b0;
        end
        slave_cnt++;
      end else begin
        wb_ack_i  = 1'b0;
        slave_cnt = 0;
      end
    end
  end

  // Observations gathered by watch(). Edge numbers count the edge the request
  // was launched on as edge 1.
  int          obs_cyc, obs_wresp, obs_rresp, obs_err, obs_first_w, obs_first_r;
  logic        obs_first_we, obs_err_with_resp, obs_unstable, obs_stuck;
  logic [31:0] obs_rdata, cap_addr, cap_data;
  logic [3:0]  cap_sel;
  logic        cap_we, prev_cyc;

  task automatic watch(input int max_edges);
    int idle;
    idle = 0;
    obs_cyc = 0; obs_wresp = 0; obs_rresp = 0; obs_err = 0;
    obs_first_w = 0; obs_first_r = 0; obs_first_we = 1'bx;
    obs_err_with_resp = 1'b0; obs_unstable = 1'b0; obs_stuck = 1'b0;
    obs_rdata = 'x; prev_cyc = 1'b0;
    for (int c = 2; c <= max_edges; c++) begin
      @(posedge clk); #1;
      if (wb_cyc_o) begin
        if (!prev_cyc) begin
          cap_addr = wb_addr_o; cap_data = wb_data_o; cap_sel = wb_sel_o; cap_we = wb_we_o;
          if (obs_cyc == 0) obs_first_we = wb_we_o;
        end else if (wb_addr_o !== cap_addr || wb_data_o !== cap_data ||
                     wb_sel_o !== cap_sel || wb_we_o !== cap_we) begin
          obs_unstable = 1'b1;
        end
        if (wb_stb_o !== 1'b1) obs_unstable = 1'b1;
        obs_cyc++;
      end
      prev_cyc = wb_cyc_o;
      if (write_response) begin
        obs_wresp++;
        if (obs_first_w == 0) obs_first_w = c;
        write_request = 1'b0;
      end
      if (read_response) begin
        obs_rresp++;
        if (obs_first_r == 0) obs_first_r = c;
        obs_rdata = read_data;
        obs_err_with_resp = bus_err_o;
        read_request = 1'b0;
      end
      if (bus_err_o) obs_err++;
      if (!read_request && !write_request) begin
        idle++;
        if (idle >= 3) break;
      end
    end
    if (read_request || write_request) obs_stuck = 1'b1;
    read_request = 1'b0;
    write_request = 1'b0;
  endtask

  task automatic launch(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
    @(posedge clk); #1;
    rw_address = addr; write_data = wdata; write_strobe = strb;
    read_request = rd; write_request = wr;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
    checks++; if (wb_addr_o !== 32'h0 || wb_data_o !== 32'h0) $display("FAIL reset_addr_data: got %h/%h expected 0/0", wb_addr_o, wb_data_o); else passed++;
    checks++; if (wb_sel_o !== 4'h0) $display("FAIL reset_sel: got %h expected 0", wb_sel_o); else passed++;
    checks++; if (read_data !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", read_data); else passed++;
    checks++; if ({read_response, write_response, bus_err_o} !== 3'b000) $display("FAIL reset_resp: got %b expected 000", {read_response, write_response, bus_err_o}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({wb_cyc_o, read_response, write_response} !== 3'b000) $display("FAIL reset_release_idle: got %b expected 000", {wb_cyc_o, read_response, write_response}); else passed++;
  endtask

  task automatic test_zero_wait_read;
    slave_waits = 0; slave_rdata = 32'hCAFE_F00D;
    launch(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'h0);
    watch(20);
    checks++; if (obs_stuck !== 1'b0) $display("FAIL zw_read_done: got stuck=%b expected 0", obs_stuck); else passed++;
    checks++; if (cap_addr !== 32'h0000_1004) $display("FAIL zw_read_addr: got %h expected 00001004", cap_addr); else passed++;
    checks++; if (cap_sel !== 4'hF) $display("FAIL zw_read_sel: got %h expected f", cap_sel); else passed++;
    checks++; if (obs_first_we !== 1'b0) $display("FAIL zw_read_we: got %b expected 0", obs_first_we); else passed++;
    checks++; if (obs_cyc != 1) $display("FAIL zw_read_cyc_len: got %0d expected 1", obs_cyc); else passed++;
    checks++; if (obs_rresp != 1 || obs_wresp != 0) $display("FAIL zw_read_resp_cnt: got r%0d w%0d expected r1 w0", obs_rresp, obs_wresp); else passed++;
    checks++; if (obs_first_r != 3) $display("FAIL zw_read_latency: got edge %0d expected 3", obs_first_r); else passed++;
    checks++; if (obs_rdata !== 32'hCAFE_F00D) $display("FAIL zw_read_data: got %h expected cafef00d", obs_rdata); else passed++;
    checks++; if (read_data !== 32'hCAFE_F00D || read_response !== 1'b0) $display("FAIL zw_read_hold: got %h/%b expected cafef00d/0", read_data, read_response); else passed++;
  endtask

  task automatic test_byte_write;
    slave_waits = 3;
    launch(1'b0, 1'b1, 32'h0000_0020, 32'h0000_00AB, 4'b0001);
    watch(30);
    checks++; if (obs_stuck !== 1'b0) $display("FAIL bw_done: got stuck=%b expected 0", obs_stuck); else passed++;
    checks++; if (obs_first_we !== 1'b1) $display("FAIL bw_we: got %b expected 1", obs_first_we); else passed++;
    checks++; if (cap_sel !== 4'b0001 || cap_data !== 32'h0000_00AB || cap_addr !== 32'h20) $display("FAIL bw_fields: got sel %h data %h addr %h expected 1/000000ab/00000020", cap_sel, cap_data, cap_addr); else passed++;
    checks++; if (obs_cyc != 4) $display("FAIL bw_cyc_len: got %0d expected 4", obs_cyc); else passed++;
    checks++; if (obs_unstable !== 1'b0) $display("FAIL bw_stable: got unstable=%b expected 0", obs_unstable); else passed++;
    checks++; if (obs_wresp != 1 || obs_rresp != 0) $display("FAIL bw_resp_cnt: got w%0d r%0d expected w1 r0", obs_wresp, obs_rresp); else passed++;
    checks++; if (obs_first_w != 6) $display("FAIL bw_latency: got edge %0d expected 6", obs_first_w); else passed++;
    checks++; if (read_data !== 32'hCAFE_F00D) $display("FAIL bw_read_data_hold: got %h expected cafef00d", read_data); else passed++;
  endtask

  task automatic test_simultaneous;
    slave_waits = 1; slave_rdata = 32'h0BAD_F00D;
    launch(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF);
    watch(40);
    checks++; if (obs_stuck !== 1'b0) $display("FAIL sim_done: got stuck=%b expected 0", obs_stuck); else passed++;
    checks++; if (obs_first_we !== 1'b1) $display("FAIL sim_write_first: got first we %b expected 1", obs_first_we); else passed++;
    checks++; if (obs_wresp != 1 || obs_rresp != 1) $display("FAIL sim_resp_cnt: got w%0d r%0d expected w1 r1", obs_wresp, obs_rresp); else passed++;
    checks++; if (obs_first_w != 4 || obs_first_r != 8) $display("FAIL sim_order: got w@%0d r@%0d expected w@4 r@8", obs_first_w, obs_first_r); else passed++;
    checks++; if (obs_cyc != 4) $display("FAIL sim_cyc_len: got %0d expected 4", obs_cyc); else passed++;
    checks++; if (obs_rdata !== 32'h0BAD_F00D) $display("FAIL sim_read_data: got %h expected 0badf00d", obs_rdata); else passed++;
  endtask

  task automatic test_ack_at_expiry;
    slave_waits = 7; slave_rdata = 32'h5A5A_1234;
    launch(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    watch(40);
    checks++; if (obs_cyc != 8) $display("FAIL late_ack_cyc_len: got %0d expected 8", obs_cyc); else passed++;
    checks++; if (obs_err != 0 || obs_rresp != 1) $display("FAIL late_ack_err: got err %0d resp %0d expected 0/1", obs_err, obs_rresp); else passed++;
    checks++; if (obs_rdata !== 32'h5A5A_1234) $display("FAIL late_ack_data: got %h expected 5a5a1234", obs_rdata); else passed++;
  endtask

  task automatic test_timeout;
    slave_waits = -1;
    launch(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
    watch(40);
    checks++; if (obs_stuck !== 1'b0) $display("FAIL to_done: got stuck=%b expected 0", obs_stuck); else passed++;
    checks++; if (obs_cyc != 8) $display("FAIL to_cyc_len: got %0d expected 8", obs_cyc); else passed++;
    checks++; if (obs_rresp != 1 || obs_err != 1) $display("FAIL to_pulses: got resp %0d err %0d expected 1/1", obs_rresp, obs_err); else passed++;
    checks++; if (obs_err_with_resp !== 1'b1) $display("FAIL to_err_same_cycle: got %b expected 1", obs_err_with_resp); else passed++;
    checks++; if (obs_rdata !== 32'hDEAD_BEEF) $display("FAIL to_read_data: got %h expected deadbeef", obs_rdata); else passed++;
    checks++; if (obs_first_r != 10) $display("FAIL to_latency: got edge %0d expected 10", obs_first_r); else passed++;
  endtask

  task automatic test_zero_strobe;
    slave_waits = 0;
    launch(1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_0000, 4'b0000);
    watch(20);
    checks++; if (obs_cyc != 0) $display("FAIL zs_no_cycle: got %0d cyc cycles expected 0", obs_cyc); else passed++;
    checks++; if (obs_wresp != 1 || obs_rresp != 0) $display("FAIL zs_resp_cnt: got w%0d r%0d expected w1 r0", obs_wresp, obs_rresp); else passed++;
    checks++; if (obs_first_w != 2) $display("FAIL zs_latency: got edge %0d expected 2", obs_first_w); else passed++;
  endtask

  task automatic test_reset_mid_write;
    logic saw_resp;
    slave_waits = -1;
    launch(1'b0, 1'b1, 32'h0000_0060, 32'h0000_5555, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) $display("FAIL rst_pre_write: got cyc %b we %b expected 1/1", wb_cyc_o, wb_we_o); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL rst_async_drop: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
    write_request = 1'b0;
    saw_resp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (read_response || write_response || bus_err_o) saw_resp = 1'b1;
    end
    checks++; if (saw_resp !== 1'b0) $display("FAIL rst_no_response: got pulse=%b expected 0", saw_resp); else passed++;
    slave_waits = 0; slave_rdata = 32'h7777_8888;
    launch(1'b1, 1'b0, 32'h0000_1008, 32'h0, 4'h0);
    watch(20);
    checks++; if (obs_rresp != 1 || obs_first_r != 3 || obs_rdata !== 32'h7777_8888) $display("FAIL rst_then_read: got r%0d @%0d data %h expected r1 @3 data 77778888", obs_rresp, obs_first_r, obs_rdata); else passed++;
    slave_en = 1'b0;
    @(posedge clk); #1;
    wb_ack_i = 1'b1; wb_data_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    @(posedge clk); #1;
    checks++; if ({wb_cyc_o, read_response, write_response, bus_err_o} !== 4'b0000) $display("FAIL spurious_ack_ctl: got %b expected 0000", {wb_cyc_o, read_response, write_response, bus_err_o}); else passed++;
    checks++; if (read_data !== 32'h7777_8888) $display("FAIL spurious_ack_data: got %h expected 77778888", read_data); else passed++;
    slave_en = 1'b1;
  endtask

  initial begin
    test_reset;
    test_zero_wait_read;
    test_byte_write;
    test_simultaneous;
    test_ack_at_expiry;
    test_timeout;
    test_zero_strobe;
    test_reset_mid_write;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/rvx_wb_bridge.md
Name: rvx_wb_bridge

Overview:
Registered bridge between the rvx_core request/response memory interface and a single-master Wishbone classic bus, as used by processorci_top and the Controller.
- Latches address, data and strobes on request acceptance.
- Holds cyc/stb stable until ack.
- Returns a one-cycle response pulse with registered read data.
- Adds byte-select generation, read/write arbitration and a bus timeout.

Parameters:
ADDR_WIDTH, 32, width of rw_address and wb_addr_o.
DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8.
TIMEOUT_CYCLES, 256, wait-state cycles without ack before abort; 0 disables timeout.
ERR_READ_DATA, 32'hDEADBEEF, read_data value returned on a timed-out read.

Ports:
clk  in  1  core clock (clk_core domain); all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
rw_address  in  ADDR_WIDTH  core access address, stable while request high
read_request  in  1  core read request, level, held until read_response
write_request  in  1  core write request, level, held until write_response
write_data  in  DATA_WIDTH  core store data
write_strobe  in  DATA_WIDTH/8  core byte enables for writes
read_data  out  DATA_WIDTH  registered read data, valid in read_response cycle
read_response  out  1  one-cycle read completion pulse
write_response  out  1  one-cycle write completion pulse
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe (equal to wb_cyc_o)
wb_we_o  out  1  Wishbone write enable
wb_addr_o  out  ADDR_WIDTH  word-aligned address {rw_address[ADDR_WIDTH-1:2],2'b00}
wb_data_o  out  DATA_WIDTH  latched write data
wb_sel_o  out  DATA_WIDTH/8  byte select
wb_data_i  in  DATA_WIDTH  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n low, async): every output 0, state IDLE, timeout counter 0. Takes effect immediately mid-transfer; no response is generated for the aborted access.
- States: IDLE, READ, WRITE, DONE.
- IDLE, edge with write_request=1:
  - Latch addr, data, sel=write_strobe; go WRITE.
  - write_request has priority when both requests are high. The read stays pending and is accepted in the next IDLE.
- IDLE, edge with only read_request=1: latch addr, sel=all ones; go READ.
- IDLE, write_request=1 with write_strobe=0: no bus cycle; go DONE with write_response set.
- READ/WRITE:
  - wb_cyc_o=wb_stb_o=1; wb_we_o=1 only in WRITE.
  - Address, data and sel held constant until ack.
- Ack handling, on an edge with wb_ack_i=1:
  - Drop cyc/stb/we; go DONE.
  - READ: read_data<=wb_data_i, read_response<=1.
  - WRITE: write_response<=1.
- DONE: response high exactly this cycle. The next edge clears the response and goes IDLE. Latency is request-sample to response = ack wait + 2 cycles; minimum with zero-wait slave is 3 edges.
- IDLE ignores requests seen in the same cycle the response is high. A request still high in the first IDLE cycle is treated as a new access.
- Timeout:
  - Counter increments each READ/WRITE cycle without ack and clears on state entry.
  - On reaching TIMEOUT_CYCLES: drop cyc/stb, go DONE, pulse the matching response and bus_err_o.
  - Read returns ERR_READ_DATA.
  - An ack arriving in the same cycle as expiry wins as a normal completion.
- wb_ack_i in IDLE or DONE is spurious and ignored; no state or output change.
- read_data holds its last value outside response cycles (0 after reset).
- rw_address[1:0] is ignored on the bus; sub-word placement is the core's responsibility via write_strobe.

Decomposition:
- Package rvx_wb_pkg:
  - state_t enum {IDLE, READ, WRITE, DONE}.
  - SEL_ALL function of DATA_WIDTH.
  - Default ERR_READ_DATA constant.
- One sub-module, wb_timeout_counter:
  - Inputs: clk, rst_n, clear, count_en.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES; tied off (expired=0) when TIMEOUT_CYCLES=0.

Test Plan:
- Zero-wait read: read_request with rw_address=32'h0000_1006; slave acks the first stb cycle with 32'hCAFE_F00D -> wb_addr_o=32'h0000_1004, wb_sel_o=4'hF, read_data=32'hCAFE_F00D with read_response high exactly one cycle, 3 edges after request.
- Byte write with 3 wait states: write_request with addr 32'h20, data 32'h0000_00AB, strobe 4'b0001 -> wb_we_o=1, wb_sel_o=4'b0001, cyc held 4 cycles; write_response one pulse after ack; read_response stays 0.
- Simultaneous requests: read and write high together -> write bus cycle first, then read cycle. Exactly one write_response followed by one read_response.
- Timeout with TIMEOUT_CYCLES=8 and no ack on a read -> cyc drops after 8 wait cycles; read_response, bus_err_o and read_data=32'hDEADBEEF all in the same cycle.
- Zero-strobe write (strobe 4'b0000) -> wb_cyc_o never asserts; write_response pulses 2 edges after request.
- Reset mid-write: rst_n low during WRITE wait -> wb_cyc_o/stb/we drop asynchronously, no response pulse. After release, a new read completes normally, and a spurious ack injected in IDLE causes no output change.
